// File: rtl/sound_pkg.sv
// Shared types, default widths and width helpers for the sound board mixer.
//   mix_state_e : sequential mixer states (IDLE, ACCUM, SAT)
//   SND_*_W     : default sample / volume / PWM widths
//   snd_acc_w   : accumulator width that cannot wrap for a given channel count
//   snd_idx_w   : channel index width (at least 1 bit)
package sound_pkg;

  localparam int unsigned SND_SAMPLE_W = 8;
  localparam int unsigned SND_VOL_W    = 4;
  localparam int unsigned SND_PWM_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SAT   = 2'd2
  } mix_state_e;

  // Product width plus enough headroom to add num_ch products without wrapping.
  function automatic int unsigned snd_acc_w(input int unsigned sample_w,
                                            input int unsigned vol_w,
                                            input int unsigned num_ch);
    return sample_w + vol_w + int'($clog2(num_ch)) + 1;
  endfunction

  function automatic int unsigned snd_idx_w(input int unsigned num_ch);
    return (num_ch > 1) ? int'($clog2(num_ch)) : 1;
  endfunction

endpackage

// File: rtl/sound_dac_core.sv
// 1-bit audio DAC stage fed by the mixer.
// Build option: SOUND_SIGMA_DELTA_EN selects a first-order sigma-delta
// modulator; otherwise a period-aligned PWM comparator is built.
// Ports:
//   clock_15   system clock
//   rst_l      asynchronous active-low reset
//   duty_load  one-cycle strobe: duty_next holds a new mix result
//   duty_next  new duty value
//   pwm_out    registered 1-bit audio output
module sound_dac_core
  import sound_pkg::*;
#(
  parameter int unsigned PWM_W = SND_PWM_W
) (
  input  logic             clock_15,
  input  logic             rst_l,
  input  logic             duty_load,
  input  logic [PWM_W-1:0] duty_next,
  output logic             pwm_out
);

  logic [PWM_W-1:0] duty_q;

`ifdef SOUND_SIGMA_DELTA_EN

  // Carry out of the phase accumulator is the output bit; ones-density = duty/2^PWM_W.
  logic [PWM_W:0] sd_q;

  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      duty_q <= '0;
      sd_q   <= '0;
    end else begin
      if (duty_load) begin
        duty_q <= duty_next;
      end
      sd_q <= {1'b0, sd_q[PWM_W-1:0]} + {1'b0, duty_q};
    end
  end

  assign pwm_out = sd_q[PWM_W];

`else

  // New duty waits in pend_q and is only taken at the period boundary.
  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] pend_q;
  logic             pwm_q;

  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q  <= '0;
      pend_q <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      if (duty_load) begin
        pend_q <= duty_next;
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) begin
        duty_q <= pend_q;
      end
      pwm_q <= (cnt_q < duty_q);
    end
  end

  assign pwm_out = pwm_q;

`endif

endmodule

// File: rtl/sound_pwm_mixer.sv
// Multi-channel audio mixer with per-channel volume and a 1-bit DAC output.
// Samples are snapshotted on sample_valid, scaled and summed one channel per
// cycle, then saturated to PWM_W bits and handed to sound_dac_core.
// Build option: SOUND_SIGMA_DELTA_EN (see sound_dac_core) changes the DAC only.
// Ports:
//   clock_15, rst_l        clock, asynchronous active-low reset
//   ch_samples             NUM_CH packed unsigned samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   sample_valid           one-cycle strobe: new sample set
//   wr_en/wr_addr/wr_data  volume register write port
//   status_clr             clears the sticky clip/overrun flags
//   busy, mix_valid        mix in progress / one-cycle result pulse
//   mix_out                last saturated mix
//   clip, overrun          sticky status flags
//   pwm_out                1-bit audio output
module sound_pwm_mixer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SAMPLE_W = SND_SAMPLE_W,
  parameter int unsigned VOL_W    = SND_VOL_W,
  parameter int unsigned PWM_W    = SND_PWM_W
) (
  input  logic                         clock_15,
  input  logic                         rst_l,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_samples,
  input  logic                         sample_valid,
  input  logic                         wr_en,
  input  logic [snd_idx_w(NUM_CH)-1:0] wr_addr,
  input  logic [VOL_W-1:0]             wr_data,
  input  logic                         status_clr,
  output logic                         busy,
  output logic                         mix_valid,
  output logic [PWM_W-1:0]             mix_out,
  output logic                         clip,
  output logic                         overrun,
  output logic                         pwm_out
);

  localparam int unsigned IDX_W   = snd_idx_w(NUM_CH);
  localparam int unsigned PROD_W  = SAMPLE_W + VOL_W;
  localparam int unsigned ACC_W   = snd_acc_w(SAMPLE_W, VOL_W, NUM_CH);
  localparam int unsigned PWM_MAX = (1 << PWM_W) - 1;

  localparam logic [IDX_W:0]   CH_COUNT = (IDX_W + 1)'(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NUM_CH - 1);

  mix_state_e state_q, state_d;

  logic [SAMPLE_W-1:0] samp_q     [NUM_CH];
  logic [VOL_W-1:0]    vol_q      [NUM_CH];
  logic [VOL_W-1:0]    vol_snap_q [NUM_CH];
  logic [IDX_W-1:0]    k_q;
  logic [ACC_W-1:0]    acc_q;
  logic                busy_q;
  logic                mix_valid_q;
  logic [PWM_W-1:0]    mix_q;
  logic                clip_q;
  logic                overrun_q;

  logic [PROD_W-1:0]   prod_c;
  logic [ACC_W-1:0]    scaled_c;
  logic                sat_hit_c;
  logic [PWM_W-1:0]    sat_val_c;
  logic                mix_load_c;
  logic                clip_set_c;
  logic                overrun_set_c;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_valid) state_d = ACCUM;
      ACCUM:   if (k_q == LAST_CH) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scale, saturate and flag-set terms.
  always_comb begin
    prod_c        = PROD_W'(samp_q[k_q]) * PROD_W'(vol_snap_q[k_q]);
    scaled_c      = acc_q >> VOL_W;
    sat_hit_c     = (scaled_c > ACC_W'(PWM_MAX));
    sat_val_c     = sat_hit_c ? '1 : scaled_c[PWM_W-1:0];
    mix_load_c    = (state_q == SAT);
    clip_set_c    = mix_load_c && sat_hit_c;
    overrun_set_c = sample_valid && busy_q;
  end

  // Volume registers; out-of-range addresses are dropped.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        vol_q[i] <= '1;
      end
    end else if (wr_en && ({1'b0, wr_addr} < CH_COUNT)) begin
      vol_q[wr_addr] <= wr_data;
    end
  end

  // Mix datapath: snapshot, sequential multiply-accumulate, saturating output.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        samp_q[i]     <= '0;
        vol_snap_q[i] <= '1;
      end
      k_q         <= '0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      mix_valid_q <= 1'b0;
      mix_q       <= '0;
    end else begin
      mix_valid_q <= mix_load_c;
      case (state_q)
        IDLE: begin
          if (sample_valid) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              samp_q[i]     <= ch_samples[i*SAMPLE_W +: SAMPLE_W];
              vol_snap_q[i] <= vol_q[i];
            end
            k_q    <= '0;
            acc_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        ACCUM: begin
          acc_q <= acc_q + ACC_W'(prod_c);
          k_q   <= k_q + 1'b1;
        end
        SAT: begin
          mix_q  <= sat_val_c;
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags; a set in the same cycle as status_clr wins.
  always_ff @(posedge clock_15 or negedge rst_l) begin
    if (!rst_l) begin
      clip_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (clip_set_c) begin
        clip_q <= 1'b1;
      end else if (status_clr) begin
        clip_q <= 1'b0;
      end
      if (overrun_set_c) begin
        overrun_q <= 1'b1;
      end else if (status_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  sound_dac_core #(
    .PWM_W (PWM_W)
  ) u_dac (
    .clock_15  (clock_15),
    .rst_l     (rst_l),
    .duty_load (mix_load_c),
    .duty_next (sat_val_c),
    .pwm_out   (pwm_out)
  );

  assign busy      = busy_q;
  assign mix_valid = mix_valid_q;
  assign mix_out   = mix_q;
  assign clip      = clip_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sound_pwm_mixer.sv
// Self-checking bench for sound_pwm_mixer (default parameters).
// Reference: mix = min((sum_i sample_i * vol_i) >> VOL_W, 2^PWM_W - 1).
// Build option SOUND_SIGMA_DELTA_EN swaps the period-alignment scenario.
module tb_sound_pwm_mixer;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned VOL_W    = 4;
  localparam int unsigned PWM_W    = 8;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned LATENCY  = NUM_CH + 1;
  localparam int unsigned PERIOD   = 1 << PWM_W;

  logic                       clock_15 = 1'b0;
  logic                       rst_l;
  logic [NUM_CH*SAMPLE_W-1:0] ch_samples;
  logic                       sample_valid;
  logic                       wr_en;
  logic [IDX_W-1:0]           wr_addr;
  logic [VOL_W-1:0]           wr_data;
  logic                       status_clr;
  logic                       busy;
  logic                       mix_valid;
  logic [PWM_W-1:0]           mix_out;
  logic                       clip;
  logic                       overrun;
  logic                       pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned model_vol [NUM_CH];

  sound_pwm_mixer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .PWM_W    (PWM_W)
  ) dut (
    .clock_15     (clock_15),
    .rst_l        (rst_l),
    .ch_samples   (ch_samples),
    .sample_valid (sample_valid),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .status_clr   (status_clr),
    .busy         (busy),
    .mix_valid    (mix_valid),
    .mix_out      (mix_out),
    .clip         (clip),
    .overrun      (overrun),
    .pwm_out      (pwm_out)
  );

  always #5 clock_15 = ~clock_15;

  task automatic tick();
    @(posedge clock_15);
    #1;
  endtask

  // Unclamped scaled sum of the sample set under the current model volumes.
  function automatic int unsigned model_raw(input logic [NUM_CH*SAMPLE_W-1:0] s);
    int unsigned sum;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum += int'(s[i*SAMPLE_W +: SAMPLE_W]) * model_vol[i];
    end
    return sum / (1 << VOL_W);
  endfunction

  function automatic int unsigned model_mix(input logic [NUM_CH*SAMPLE_W-1:0] s);
    int unsigned r;
    r = model_raw(s);
    return (r > PERIOD - 1) ? PERIOD - 1 : r;
  endfunction

  task automatic write_vol(input int unsigned ch, input int unsigned v);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(ch);
    wr_data = VOL_W'(v);
    tick();
    wr_en   = 1'b0;
    model_vol[ch] = v;
  endtask

  task automatic clear_flags();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
  endtask

  // Strobe one sample set and wait (bounded) for the result pulse.
  task automatic run_mix(input logic [NUM_CH*SAMPLE_W-1:0] s,
                         output logic [PWM_W-1:0] res, output int lat,
                         output bit got, output bit busy_after);
    got = 1'b0;
    lat = -1;
    res = '0;
    ch_samples   = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    busy_after   = busy;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (mix_valid) begin
        got = 1'b1;
        lat = n;
        res = mix_out;
        break;
      end
    end
  endtask

  function automatic logic [NUM_CH*SAMPLE_W-1:0] all_samples(input logic [SAMPLE_W-1:0] b);
    logic [NUM_CH*SAMPLE_W-1:0] t;
    for (int i = 0; i < NUM_CH; i++) t[i*SAMPLE_W +: SAMPLE_W] = b;
    return t;
  endfunction

  task automatic test_reset();
    rst_l = 1'b0;
    #22;
    n_tests++;
    if ({busy, mix_valid, clip, overrun, pwm_out} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {busy, mix_valid, clip, overrun, pwm_out});
    end
    n_tests++;
    if (mix_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mix_out: got %0h expected 0", mix_out);
    end
    rst_l = 1'b1;
    tick();
    for (int i = 0; i < NUM_CH; i++) model_vol[i] = 15;
  endtask

  task automatic test_basic();
    logic [PWM_W-1:0] res;
    int lat;
    bit got, busy_after;
    run_mix(all_samples(8'h40), res, lat, got, busy_after);
    n_tests++;
    if (!got || lat != int'(LATENCY)) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d (seen %0d) expected %0d", lat, got, LATENCY);
    end
    n_tests++;
    if (res !== PWM_W'(model_mix(all_samples(8'h40))) || res !== 8'hF0) begin
      n_fail++;
      $display("FAIL basic_mix: got %0h expected f0", res);
    end
    n_tests++;
    if (busy_after !== 1'b1 || busy !== 1'b0 || clip !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_clip: got busy_after=%b busy=%b clip=%b expected 1 0 0",
               busy_after, busy, clip);
    end
    tick();
    n_tests++;
    if (mix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_pulse_width: got %b expected 0", mix_valid);
    end
  endtask

  task automatic test_clip();
    logic [PWM_W-1:0] res;
    int lat;
    bit got, busy_after;
    run_mix(all_samples(8'h80), res, lat, got, busy_after);
    n_tests++;
    if (!got || res !== 8'hFF || clip !== 1'b1 || model_raw(all_samples(8'h80)) != 480) begin
      n_fail++;
      $display("FAIL clip_sat: got mix=%0h clip=%b expected ff 1", res, clip);
    end
    clear_flags();
    n_tests++;
    if (clip !== 1'b0) begin
      n_fail++;
      $display("FAIL clip_clear: got %b expected 0", clip);
    end
    // Clear held across the saturating mix: the set must win.
    status_clr = 1'b1;
    run_mix(all_samples(8'h80), res, lat, got, busy_after);
    n_tests++;
    if (!got || clip !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_set_wins: got %b expected 1", clip);
    end
    status_clr = 1'b0;
    tick();
    n_tests++;
    if (clip !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_sticky: got %b expected 1", clip);
    end
  endtask

  task automatic test_pwm_window();
    logic [NUM_CH*SAMPLE_W-1:0] s;
    logic [PWM_W-1:0] res;
    int lat, ones;
    bit got, busy_after;
    write_vol(0, 8);
    for (int i = 1; i < NUM_CH; i++) write_vol(i, 0);
    s = NUM_CH*SAMPLE_W'($urandom);
    s[SAMPLE_W-1:0] = 8'h80;
    run_mix(s, res, lat, got, busy_after);
    n_tests++;
    if (!got || res !== PWM_W'(model_mix(s)) || res !== 8'h40) begin
      n_fail++;
      $display("FAIL pwm_mix: got %0h expected 40", res);
    end
    repeat (300) tick();
    for (int w = 0; w < 2; w++) begin
      ones = 0;
      for (int c = 0; c < int'(PERIOD); c++) begin
        tick();
        ones += int'(pwm_out);
      end
      n_tests++;
      if (ones != 64) begin
        n_fail++;
        $display("FAIL pwm_density_%0d: got %0d ones expected 64", w, ones);
      end
    end
  endtask

`ifndef SOUND_SIGMA_DELTA_EN
  // A new mix mid-period must not disturb the current period.
  task automatic test_pwm_align();
    logic [NUM_CH*SAMPLE_W-1:0] s;
    logic prev;
    bit found;
    int ones, mv;
    write_vol(0, 15);
    s = all_samples(8'h00);
    s[SAMPLE_W-1:0] = 8'h80;
    found = 1'b0;
    prev  = pwm_out;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (!prev && pwm_out) begin
        found = 1'b1;
        break;
      end
      prev = pwm_out;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL align_edge: got no rising edge expected one within 600 cycles");
    end else begin
      ones = 1;
      mv   = 0;
      ch_samples = s;
      for (int c = 1; c < int'(PERIOD); c++) begin
        sample_valid = (c == 20);
        tick();
        ones += int'(pwm_out);
        mv   += int'(mix_valid);
      end
      sample_valid = 1'b0;
      n_tests++;
      if (ones != 64 || mv != 1) begin
        n_fail++;
        $display("FAIL align_old_period: got %0d ones %0d pulses expected 64 1", ones, mv);
      end
      ones = 0;
      for (int c = 0; c < int'(PERIOD); c++) begin
        tick();
        ones += int'(pwm_out);
      end
      n_tests++;
      if (ones != int'(model_mix(s)) || ones != 120) begin
        n_fail++;
        $display("FAIL align_new_period: got %0d ones expected 120", ones);
      end
    end
  endtask
`endif

  task automatic test_duty_zero();
    logic [PWM_W-1:0] res;
    int lat, ones;
    bit got, busy_after;
    for (int i = 0; i < NUM_CH; i++) write_vol(i, 0);
    run_mix(all_samples(8'hFF), res, lat, got, busy_after);
    n_tests++;
    if (!got || res !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_mix: got %0h expected 0", res);
    end
    repeat (300) tick();
    ones = 0;
    for (int c = 0; c < int'(PERIOD); c++) begin
      tick();
      ones += int'(pwm_out);
    end
    n_tests++;
    if (ones != 0) begin
      n_fail++;
      $display("FAIL zero_density: got %0d ones expected 0", ones);
    end
  endtask

  task automatic test_overrun();
    logic [NUM_CH*SAMPLE_W-1:0] a, b;
    logic [PWM_W-1:0] res, first;
    int lat, mv, exp_a_old;
    bit got, busy_after;
    for (int i = 0; i < NUM_CH; i++) write_vol(i, $urandom_range(15, 1));
    clear_flags();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear0: got %b expected 0", overrun);
    end
    a = NUM_CH*SAMPLE_W'($urandom);
    b = ~a;
    exp_a_old = int'(model_mix(a));
    ch_samples   = a;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    // Second strobe plus a volume write while the first mix accumulates.
    ch_samples   = b;
    sample_valid = 1'b1;
    wr_en        = 1'b1;
    wr_addr      = 2'd0;
    wr_data      = 4'd1;
    tick();
    sample_valid = 1'b0;
    wr_en        = 1'b0;
    model_vol[0] = 1;
    mv    = 0;
    first = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (mix_valid) begin
        if (mv == 0) first = mix_out;
        mv++;
      end
    end
    n_tests++;
    if (mv != 1) begin
      n_fail++;
      $display("FAIL overrun_pulses: got %0d expected 1", mv);
    end
    n_tests++;
    if (first !== PWM_W'(exp_a_old)) begin
      n_fail++;
      $display("FAIL overrun_result: got %0h expected %0h", first, exp_a_old);
    end
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_flag: got %b expected 1", overrun);
    end
    run_mix(a, res, lat, got, busy_after);
    n_tests++;
    if (!got || res !== PWM_W'(model_mix(a))) begin
      n_fail++;
      $display("FAIL vol_next_snapshot: got %0h expected %0h", res, model_mix(a));
    end
    clear_flags();
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_random();
    logic [NUM_CH*SAMPLE_W-1:0] s;
    logic [PWM_W-1:0] res;
    int lat;
    bit got, busy_after, exp_clip;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < NUM_CH; i++) write_vol(i, $urandom_range(15, 0));
      s = NUM_CH*SAMPLE_W'($urandom);
      if (it % 4 == 0) s = s | all_samples(8'hC0);
      clear_flags();
      exp_clip = (model_raw(s) > PERIOD - 1);
      run_mix(s, res, lat, got, busy_after);
      n_tests++;
      if (!got || lat != int'(LATENCY) || res !== PWM_W'(model_mix(s)) || clip !== exp_clip) begin
        n_fail++;
        $display("FAIL random_%0d: got mix=%0h lat=%0d clip=%b expected mix=%0h lat=%0d clip=%b",
                 it, res, lat, clip, model_mix(s), LATENCY, exp_clip);
      end
    end
  endtask

  task automatic test_reset_mid_accum();
    logic [PWM_W-1:0] res;
    int lat, mv;
    bit got, busy_after;
    write_vol(1, 3);
    ch_samples   = all_samples(8'h55);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    tick();
    #2;
    rst_l = 1'b0;
    #2;
    n_tests++;
    if ({busy, mix_valid, pwm_out, clip, overrun} !== 5'b0 || mix_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midreset_state: got flags=%b mix=%0h expected 00000 0",
               {busy, mix_valid, pwm_out, clip, overrun}, mix_out);
    end
    #2;
    rst_l = 1'b1;
    for (int i = 0; i < NUM_CH; i++) model_vol[i] = 15;
    mv = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      mv += int'(mix_valid);
    end
    n_tests++;
    if (mv != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_abandon: got %0d pulses busy=%b expected 0 0", mv, busy);
    end
    run_mix(all_samples(8'h40), res, lat, got, busy_after);
    n_tests++;
    if (!got || res !== 8'hF0) begin
      n_fail++;
      $display("FAIL midreset_vol_default: got %0h expected f0", res);
    end
  endtask

  initial begin
    ch_samples   = '0;
    sample_valid = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    status_clr   = 1'b0;
    test_reset();
    test_basic();
    test_clip();
    test_pwm_window();
`ifndef SOUND_SIGMA_DELTA_EN
    test_pwm_align();
`endif
    test_duty_zero();
    test_overrun();
    test_random();
    test_reset_mid_accum();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_pwm_mixer.md
Name: sound_pwm_mixer

Overview:
Parametrised multi-channel audio mixer and PWM DAC for the sound board; generalises the single-POKEY PWM output stage.
- Takes NUM_CH unsigned channel samples (POKEY, YM2151, speech) on a strobe.
- Applies per-channel CPU-writable volume, sums sequentially and saturates.
- Drives one 1-bit PWM audio pin, with period-aligned duty updates.

Parameters:
NUM_CH, 4, number of input channels (1..16)
SAMPLE_W, 8, channel sample width, unsigned offset-binary
VOL_W, 4, volume register width; gain = vol / 2^VOL_W
PWM_W, 8, PWM counter/duty width; mixed result is saturated to this width

Ports:
clock_15  in  1  system clock
rst_l  in  1  asynchronous active-low reset
ch_samples  in  NUM_CH*SAMPLE_W  channel i at [i*SAMPLE_W +: SAMPLE_W]
sample_valid  in  1  one-cycle strobe: new sample set present
wr_en  in  1  volume register write strobe
wr_addr  in  $clog2(NUM_CH) (min 1)  channel index
wr_data  in  VOL_W  volume value
status_clr  in  1  clears the sticky flags
busy  out  1  mix in progress
mix_valid  out  1  one-cycle pulse when mix_out updates
mix_out  out  PWM_W  last saturated mix
clip  out  1  sticky: a mix saturated
overrun  out  1  sticky: sample_valid arrived while busy
pwm_out  out  1  PWM audio output

Behaviour:
- Reset (async, rst_l low): FSM IDLE; busy/mix_valid/clip/overrun/pwm_out = 0; mix_out = 0; duty = 0; PWM counter = 0; all volumes = all-ones.
- Volume write: wr_en=1 writes vol[wr_addr] <= wr_data on the clock edge. wr_addr >= NUM_CH is ignored. A write is legal at any time and takes effect at the next snapshot.
- FSM states: IDLE, ACCUM, SAT.
  - IDLE + sample_valid: snapshot all samples and volumes, clear acc, channel index k = 0 -> ACCUM; busy = 1 from the next cycle.
  - ACCUM: acc += sample[k] * vol[k]; k++. After k = NUM_CH-1 -> SAT. Takes exactly NUM_CH cycles.
  - SAT: r = acc >> VOL_W. mix_out = min(r, 2^PWM_W - 1); if clamped, clip <= 1. mix_valid pulses and pending_duty <= mix_out -> IDLE; busy = 0 in the same cycle as mix_valid.
- Latency: sample_valid at cycle 0 -> mix_valid at cycle NUM_CH+1.
- Arithmetic widths:
  - Product is SAMPLE_W+VOL_W bits.
  - acc is SAMPLE_W+VOL_W+$clog2(NUM_CH)+1 bits and can never wrap.
  - All arithmetic is unsigned.
- sample_valid while busy: ignored, overrun <= 1; the mix in flight is unaffected.
- Sticky flags: status_clr clears clip and overrun. If a set and status_clr occur in the same cycle, set wins.
- PWM:
  - PWM_W-bit free-running counter, increments every clock and wraps.
  - duty <= pending_duty only in the cycle the counter equals 2^PWM_W - 1, so the update is glitch-free at the period boundary.
  - pwm_out registered = (counter < duty). duty 0 gives constant low; max duty gives high for 2^PWM_W - 1 of 2^PWM_W cycles.
- rst_l asserted mid-ACCUM: the mix is abandoned, no mix_valid, all state returns to reset values.

Optional Feature:
SOUND_SIGMA_DELTA_EN
- Defined: the PWM comparator is replaced by a first-order sigma-delta modulator.
  - (PWM_W+1)-bit accumulator: sd <= sd[PWM_W-1:0] + duty; pwm_out = carry.
  - duty updates immediately on mix_valid (no period alignment).
  - Ones-density = duty / 2^PWM_W; any 2^PWM_W-cycle window has exactly duty ones for constant duty.
- Undefined: PWM comparator as in Behaviour.
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Package sound_pkg holds:
  - mixer state enum (IDLE/ACCUM/SAT)
  - default widths: SND_SAMPLE_W=8, SND_VOL_W=4, SND_PWM_W=8
  - helper function for accumulator width
- One sub-module: sound_dac_core, containing the counter/duty/comparator or sigma-delta logic and the period-aligned duty load.

Test Plan:
Defaults throughout (NUM_CH=4, SAMPLE_W=8, VOL_W=4, PWM_W=8).
- After reset, all vols 15, samples all 0x40, strobe -> mix_valid at cycle 5, mix_out=0xF0, clip=0.
- Samples all 0x80, vols 15 -> acc 7680, r=480 -> mix_out=0xFF, clip=1. status_clr -> clip=0; clip and clear in the same cycle -> clip stays 1.
- vol[0]=8, vol[1..3]=0, ch0=0x80 -> mix_out=0x40. After the next counter wrap, pwm_out is high exactly 64 of 256 cycles per period; duty does not change mid-period.
- Strobe, then a second strobe 2 cycles later -> overrun=1, exactly one mix_valid, result from the first sample set. Volume write during ACCUM does not affect the current mix.
- rst_l low during ACCUM -> no mix_valid; busy=0, mix_out=0, pwm_out=0, volumes back to 15.
- With SOUND_SIGMA_DELTA_EN, mix_out=0x40 -> exactly 64 ones in every 256-cycle window once settled; duty 0 -> constant 0.
